// File: rtl/demux12_if.sv
// Handshake bundle for the 1:2 registered demux: one upstream port, two
// downstream ports and the per-output delivery counters.
interface demux12_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  modport master (
    output in_data, in_sel, in_valid, out0_ready, out1_ready,
    input  in_ready, out0_data, out0_valid, out1_data, out1_valid, cnt0, cnt1
  );

  modport slave (
    input  in_data, in_sel, in_valid, out0_ready, out1_ready,
    output in_ready, out0_data, out0_valid, out1_data, out1_valid, cnt0, cnt1
  );
endinterface

// File: rtl/demux12_reg.sv
// 1-to-2 registered demultiplexer: each accepted word lands in the one-entry
// holding register chosen by in_sel; delivered words are counted per output.
//
// state      | meaning
// SLOT_EMPTY | holding register has no word, outk_valid = 0
// SLOT_FULL  | holding register has a word,  outk_valid = 1
module demux12_reg #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  demux12_if.slave    bus
);
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  slot_state_e      slot0_q, slot0_d;
  slot_state_e      slot1_q, slot1_d;
  logic [WIDTH-1:0] data0_q, data0_d;
  logic [WIDTH-1:0] data1_q, data1_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  logic drain0, drain1;
  logic in_ready;
  logic accept, load0, load1;

  always_ff @(posedge clk) begin
    if (rst) begin
      slot0_q <= SLOT_EMPTY;
      slot1_q <= SLOT_EMPTY;
      data0_q <= '0;
      data1_q <= '0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  always_comb begin
    drain0   = (slot0_q == SLOT_FULL) && bus.out0_ready;
    drain1   = (slot1_q == SLOT_FULL) && bus.out1_ready;

    // Readiness looks only at the targeted slot, so a stalled output never
    // blocks words headed for the other one.
    in_ready = 1'b0;
    if (!rst) begin
      if (bus.in_sel) in_ready = (slot1_q == SLOT_EMPTY) || bus.out1_ready;
      else            in_ready = (slot0_q == SLOT_EMPTY) || bus.out0_ready;
    end

    accept   = bus.in_valid && in_ready;
    load0    = accept && !bus.in_sel;
    load1    = accept && bus.in_sel;

    slot0_d  = slot0_q;
    slot1_d  = slot1_q;
    data0_d  = data0_q;
    data1_d  = data1_q;
    cnt0_d   = cnt0_q;
    cnt1_d   = cnt1_q;

    case (slot0_q)
      SLOT_EMPTY: if (load0)           slot0_d = SLOT_FULL;
      SLOT_FULL:  if (drain0 && !load0) slot0_d = SLOT_EMPTY;
    endcase

    case (slot1_q)
      SLOT_EMPTY: if (load1)           slot1_d = SLOT_FULL;
      SLOT_FULL:  if (drain1 && !load1) slot1_d = SLOT_EMPTY;
    endcase

    if (load0)  data0_d = bus.in_data;
    if (load1)  data1_d = bus.in_data;
    if (drain0) cnt0_d  = cnt0_q + 1'b1;
    if (drain1) cnt1_d  = cnt1_q + 1'b1;
  end

  assign bus.in_ready   = in_ready;
  assign bus.out0_data  = data0_q;
  assign bus.out0_valid = (slot0_q == SLOT_FULL);
  assign bus.out1_data  = data1_q;
  assign bus.out1_valid = (slot1_q == SLOT_FULL);
  assign bus.cnt0       = cnt0_q;
  assign bus.cnt1       = cnt1_q;
endmodule

// File: tb/tb_demux12_reg.sv
// Directed bench for demux12_reg; counters built 4 bits wide so wrap is reachable.
module tb_demux12_reg;
  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  demux12_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  demux12_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_data    = '0;
    bus.in_sel     = 1'b0;
    bus.in_valid   = 1'b0;
    bus.out0_ready = 1'b0;
    bus.out1_ready = 1'b0;

    // reset then idle
    #1;
    chk("rdy_in_rst", 32'(bus.in_ready), 32'd0);
    tick();
    tick();
    chk("rst_v0", 32'(bus.out0_valid), 32'd0);
    chk("rst_v1", 32'(bus.out1_valid), 32'd0);
    chk("rst_d0", bus.out0_data, 32'd0);
    chk("rst_d1", bus.out1_data, 32'd0);
    chk("rst_c0", 32'(bus.cnt0), 32'd0);
    chk("rst_c1", 32'(bus.cnt1), 32'd0);
    chk("rdy_rst_hi", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rdy_after_rst", 32'(bus.in_ready), 32'd1);

    // single route to out0
    bus.in_data = 32'hABCEDF12; bus.in_sel = 1'b0; bus.in_valid = 1'b1;
    bus.out0_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("s2_v0", 32'(bus.out0_valid), 32'd1);
    chk("s2_d0", bus.out0_data, 32'hABCEDF12);
    chk("s2_v1", 32'(bus.out1_valid), 32'd0);
    chk("s2_c0_pre", 32'(bus.cnt0), 32'd0);
    tick();
    chk("s2_v0_drained", 32'(bus.out0_valid), 32'd0);
    chk("s2_c0", 32'(bus.cnt0), 32'd1);

    // back-to-back stream to out1
    bus.out1_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_data = 32'h12345678 + 32'(i); bus.in_sel = 1'b1; bus.in_valid = 1'b1;
      #1;
      chk("s3_rdy", 32'(bus.in_ready), 32'd1);
      tick();
      chk("s3_v1", 32'(bus.out1_valid), 32'd1);
      chk("s3_d1", bus.out1_data, 32'h12345678 + 32'(i));
      chk("s3_c1_lag", 32'(bus.cnt1), 32'(i));
    end
    bus.in_valid = 1'b0;
    tick();
    chk("s3_v1_end", 32'(bus.out1_valid), 32'd0);
    chk("s3_c1", 32'(bus.cnt1), 32'd4);
    chk("s3_c0_kept", 32'(bus.cnt0), 32'd1);

    // stall isolation
    bus.out0_ready = 1'b0; bus.out1_ready = 1'b0;
    bus.in_data = 32'hABCEDF12; bus.in_sel = 1'b0; bus.in_valid = 1'b1;
    tick();
    chk("s4_fill_v0", 32'(bus.out0_valid), 32'd1);
    bus.in_data = 32'h12345678; bus.in_sel = 1'b0;
    #1;
    chk("s4_rdy_blk", 32'(bus.in_ready), 32'd0);
    tick();
    chk("s4_d0_hold", bus.out0_data, 32'hABCEDF12);
    chk("s4_v0_hold", 32'(bus.out0_valid), 32'd1);
    bus.in_sel = 1'b1;
    #1;
    chk("s4_rdy_other", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("s4_v1", 32'(bus.out1_valid), 32'd1);
    chk("s4_d1", bus.out1_data, 32'h12345678);
    chk("s4_d0_still", bus.out0_data, 32'hABCEDF12);
    chk("s4_c0", 32'(bus.cnt0), 32'd1);

    // reset mid-operation with both slots full and stalled
    rst = 1'b1;
    #1;
    chk("s6_rdy_rst", 32'(bus.in_ready), 32'd0);
    tick();
    rst = 1'b0;
    chk("s6_v0", 32'(bus.out0_valid), 32'd0);
    chk("s6_v1", 32'(bus.out1_valid), 32'd0);
    chk("s6_d0", bus.out0_data, 32'd0);
    chk("s6_d1", bus.out1_data, 32'd0);
    chk("s6_c0", 32'(bus.cnt0), 32'd0);
    chk("s6_c1", 32'(bus.cnt1), 32'd0);
    bus.in_data = 32'hABCEDF12; bus.in_sel = 1'b0; bus.in_valid = 1'b1;
    bus.out0_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("s6_re_v0", 32'(bus.out0_valid), 32'd1);
    chk("s6_re_d0", bus.out0_data, 32'hABCEDF12);
    chk("s6_re_v1", 32'(bus.out1_valid), 32'd0);
    tick();
    chk("s6_re_c0", 32'(bus.cnt0), 32'd1);

    // counter wrap: 17 drains on a 4-bit counter
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.out0_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus.in_data = 32'(i); bus.in_sel = 1'b0; bus.in_valid = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    chk("s5_c0_16", 32'(bus.cnt0), 32'd0);
    chk("s5_d0_last", bus.out0_data, 32'd16);
    tick();
    chk("s5_c0_wrap", 32'(bus.cnt0), 32'd1);

    // both slots drain on one edge while only out0 reloads
    bus.out0_ready = 1'b0; bus.out1_ready = 1'b0;
    bus.in_data = 32'h11; bus.in_sel = 1'b0; bus.in_valid = 1'b1;
    tick();
    bus.in_data = 32'h22; bus.in_sel = 1'b1;
    tick();
    bus.out0_ready = 1'b1; bus.out1_ready = 1'b1;
    bus.in_data = 32'h33; bus.in_sel = 1'b0;
    #1;
    chk("dd_rdy", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("dd_c0", 32'(bus.cnt0), 32'd2);
    chk("dd_c1", 32'(bus.cnt1), 32'd1);
    chk("dd_v0", 32'(bus.out0_valid), 32'd1);
    chk("dd_d0", bus.out0_data, 32'h33);
    chk("dd_v1", 32'(bus.out1_valid), 32'd0);
    tick();
    chk("dd_c0_end", 32'(bus.cnt0), 32'd3);
    chk("dd_v0_end", 32'(bus.out0_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
